// File: rtl/io_uart_bridge_if.sv
// I/O-bus and UART-side signal bundle for io_uart_bridge.
// master: processor/UART environment; slave: the bridge.
interface io_uart_bridge_if;
  logic [7:0] IO_port_ID;
  logic       IO_write_strobe;
  logic [7:0] IO_write_data;
  logic       IO_read_strobe;
  logic [7:0] IO_read_data;
  logic [7:0] tx_data_in;
  logic       write_tx_data;
  logic       tx_buffer_full;
  logic [7:0] rx_data_out;
  logic       rx_data_present;
  logic       read_rx_data_ack;
  logic       tx_overflow;

  modport master (
    output IO_port_ID, IO_write_strobe,
    output IO_write_data, IO_read_strobe,
    output tx_buffer_full, rx_data_out,
    output rx_data_present,
    input  IO_read_data, tx_data_in,
    input  write_tx_data, read_rx_data_ack,
    input  tx_overflow
  );

  modport slave (
    input  IO_port_ID, IO_write_strobe,
    input  IO_write_data, IO_read_strobe,
    input  tx_buffer_full, rx_data_out,
    input  rx_data_present,
    output IO_read_data, tx_data_in,
    output write_tx_data, read_rx_data_ack,
    output tx_overflow
  );
endinterface

// File: rtl/io_uart_bridge.sv
// Registered I/O-port bridge: TX FIFO drained into the UART,
// edge-qualified strobes, registered read data.
module io_uart_bridge #(
  parameter int FIFO_AW = 4
) (
  input logic             clk,
  input logic             reset,
  io_uart_bridge_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_e;

  state_e state_q, state_d;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               wstb_q, rstb_q;
  logic [7:0]         rdata_q, rdata_d;
  logic [7:0]         txd_q, txd_d;
  logic               wtx_q, wtx_d;
  logic               ack_q, ack_d;
  logic               ovf_q, ovf_d;
  logic               wr_ev, rd_ev;
  logic               full, empty;
  logic               wr_p1, push, drop, pop;

  assign wr_ev = bus.IO_write_strobe & ~wstb_q;
  assign rd_ev = bus.IO_read_strobe & ~rstb_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign wr_p1 = wr_ev && (bus.IO_port_ID == 8'h01);
  // fullness is judged before any same-cycle pop
  assign push  = wr_p1 && !full;
  assign drop  = wr_p1 && full;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    wtx_d   = 1'b0;
    txd_d   = txd_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (!empty && !bus.tx_buffer_full) begin
          state_d = SEND;
          pop     = 1'b1;
          wtx_d   = 1'b1;
          txd_d   = mem_q[rptr_q];
        end
      end
      SEND:    state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) wptr_d = wptr_q + FIFO_AW'(1);
    if (pop)  rptr_d = rptr_q + FIFO_AW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);

    if (rd_ev) begin
      case (bus.IO_port_ID)
        8'h01: rdata_d = bus.rx_data_present ?
                         bus.rx_data_out : 8'h00;
        8'h02: rdata_d = {7'b0, bus.rx_data_present};
        8'h03: rdata_d = {7'b0, full};
        8'h04: rdata_d = 8'(cnt_q);
        8'h05: rdata_d = {7'b0, ovf_q};
        default: rdata_d = 8'h00;
      endcase
      ack_d = (bus.IO_port_ID == 8'h01) &&
              bus.rx_data_present;
      if (bus.IO_port_ID == 8'h05) ovf_d = 1'b0;
    end
    // a new drop wins over a same-cycle clear
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      wstb_q  <= 1'b0;
      rstb_q  <= 1'b0;
      rdata_q <= 8'h00;
      txd_q   <= 8'h00;
      wtx_q   <= 1'b0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      wstb_q  <= bus.IO_write_strobe;
      rstb_q  <= bus.IO_read_strobe;
      rdata_q <= rdata_d;
      txd_q   <= txd_d;
      wtx_q   <= wtx_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.IO_write_data;
  end

  assign bus.IO_read_data     = rdata_q;
  assign bus.tx_data_in       = txd_q;
  assign bus.write_tx_data    = wtx_q;
  assign bus.read_rx_data_ack = ack_q;
  assign bus.tx_overflow      = ovf_q;
endmodule

// File: tb/tb_io_uart_bridge.sv
// Directed self-checking bench for io_uart_bridge.
// UART pulses and acks are logged on the falling edge.
module tb_io_uart_bridge;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ack_cnt = 0;
  logic [7:0] txlog [$];
  int   tstamp [$];

  always #5 clk = ~clk;

  io_uart_bridge_if bus ();

  io_uart_bridge #(.FIFO_AW(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.write_tx_data) begin
      txlog.push_back(bus.tx_data_in);
      tstamp.push_back(cyc);
    end
    if (bus.read_rx_data_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] p,
                    input logic [7:0] d);
    bus.IO_port_ID      = p;
    bus.IO_write_data   = d;
    bus.IO_write_strobe = 1'b1;
    tick();
    bus.IO_write_strobe = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [7:0] p,
                    output logic [7:0] v);
    bus.IO_port_ID     = p;
    bus.IO_read_strobe = 1'b1;
    tick();
    v = bus.IO_read_data;
    bus.IO_read_strobe = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] v;
    int base;
    int a0;
    int n;

    bus.IO_port_ID      = 8'h00;
    bus.IO_write_strobe = 1'b0;
    bus.IO_write_data   = 8'h00;
    bus.IO_read_strobe  = 1'b0;
    bus.tx_buffer_full  = 1'b0;
    bus.rx_data_out     = 8'h00;
    bus.rx_data_present = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_rdata", bus.IO_read_data, 8'h00);
    chk("rst_txd", bus.tx_data_in, 8'h00);
    chk("rst_wtx", bus.write_tx_data, 1'b0);
    chk("rst_ack", bus.read_rx_data_ack, 1'b0);
    chk("rst_ovf", bus.tx_overflow, 1'b0);
    reset = 1'b0;
    tick();

    // basic send of three bytes
    base = txlog.size();
    bus.IO_port_ID      = 8'h01;
    bus.IO_write_data   = 8'h41;
    bus.IO_write_strobe = 1'b1;
    tick();
    chk("lat_e0_wtx", bus.write_tx_data, 1'b0);
    bus.IO_write_strobe = 1'b0;
    tick();
    chk("lat_e1_wtx", bus.write_tx_data, 1'b1);
    chk("lat_e1_txd", bus.tx_data_in, 8'h41);
    tick();
    chk("pulse_end", bus.write_tx_data, 1'b0);
    wr(8'h01, 8'h42);
    wr(8'h01, 8'h43);
    repeat (6) tick();
    chk("t1_npulse", txlog.size() - base, 3);
    if (txlog.size() - base == 3) begin
      chk("t1_b0", txlog[base], 8'h41);
      chk("t1_b1", txlog[base+1], 8'h42);
      chk("t1_b2", txlog[base+2], 8'h43);
      chk("t1_gap0", tstamp[base+1] - tstamp[base], 3);
      chk("t1_gap1", tstamp[base+2] - tstamp[base+1], 3);
    end
    chk("t1_txd_hold", bus.tx_data_in, 8'h43);
    rd(8'h04, v);
    chk("t1_count", v, 8'h00);

    // fill past capacity
    bus.tx_buffer_full = 1'b1;
    for (int i = 0; i < 17; i++) wr(8'h01, 8'(8'h80 + i));
    rd(8'h03, v);
    chk("t2_full", v, 8'h01);
    rd(8'h04, v);
    chk("t2_count", v, 8'h10);
    chk("t2_ovf", bus.tx_overflow, 1'b1);
    rd(8'h05, v);
    chk("t2_rd_ovf", v, 8'h01);
    chk("t2_ovf_clr", bus.tx_overflow, 1'b0);
    base = txlog.size();
    bus.tx_buffer_full = 1'b0;
    repeat (60) tick();
    chk("t2_ndrain", txlog.size() - base, 16);
    if (txlog.size() - base == 16)
      for (int i = 0; i < 16; i++)
        chk("t2_order", txlog[base+i], 8'(8'h80 + i));
    rd(8'h04, v);
    chk("t2_empty", v, 8'h00);

    // long write strobe pushes once
    bus.tx_buffer_full  = 1'b1;
    bus.IO_port_ID      = 8'h01;
    bus.IO_write_data   = 8'h55;
    bus.IO_write_strobe = 1'b1;
    repeat (5) tick();
    bus.IO_write_strobe = 1'b0;
    tick();
    rd(8'h04, v);
    chk("t3_count", v, 8'h01);
    base = txlog.size();
    bus.tx_buffer_full = 1'b0;
    repeat (10) tick();
    chk("t3_npulse", txlog.size() - base, 1);
    if (txlog.size() - base == 1)
      chk("t3_byte", txlog[base], 8'h55);

    // long read strobe on rx port
    a0 = ack_cnt;
    bus.rx_data_present = 1'b1;
    bus.rx_data_out     = 8'h7E;
    bus.IO_port_ID      = 8'h01;
    bus.IO_read_strobe  = 1'b1;
    tick();
    chk("t4_rdata", bus.IO_read_data, 8'h7E);
    chk("t4_ack_hi", bus.read_rx_data_ack, 1'b1);
    repeat (3) tick();
    bus.IO_read_strobe = 1'b0;
    tick();
    chk("t4_nack", ack_cnt - a0, 1);
    chk("t4_hold", bus.IO_read_data, 8'h7E);
    bus.rx_data_present = 1'b0;
    bus.IO_read_strobe  = 1'b1;
    repeat (4) tick();
    bus.IO_read_strobe = 1'b0;
    tick();
    chk("t4_nodata", bus.IO_read_data, 8'h00);
    chk("t4_nack2", ack_cnt - a0, 1);
    bus.rx_data_present = 1'b1;
    rd(8'h02, v);
    chk("t4_present", v, 8'h01);
    rd(8'h09, v);
    chk("t4_unmapped", v, 8'h00);
    bus.rx_data_present = 1'b0;

    // reset in the middle of a send
    bus.tx_buffer_full = 1'b1;
    for (int i = 0; i < 5; i++) wr(8'h01, 8'(8'h90 + i));
    bus.tx_buffer_full = 1'b0;
    n = 0;
    while (!bus.write_tx_data && n < 10) begin
      tick();
      n++;
    end
    chk("t5_send_seen", bus.write_tx_data, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_async", bus.write_tx_data, 1'b0);
    tick();
    reset = 1'b0;
    base = txlog.size();
    repeat (20) tick();
    chk("t5_npulse", txlog.size() - base, 0);
    rd(8'h04, v);
    chk("t5_count", v, 8'h00);

    // push and pop on the same edge
    bus.tx_buffer_full = 1'b1;
    wr(8'h01, 8'hA1);
    wr(8'h01, 8'hA2);
    wr(8'h01, 8'hA3);
    rd(8'h04, v);
    chk("t6_pre", v, 8'h03);
    base = txlog.size();
    bus.IO_port_ID      = 8'h01;
    bus.IO_write_data   = 8'hA4;
    bus.tx_buffer_full  = 1'b0;
    bus.IO_write_strobe = 1'b1;
    tick();
    bus.IO_write_strobe = 1'b0;
    bus.IO_port_ID      = 8'h04;
    bus.IO_read_strobe  = 1'b1;
    tick();
    chk("t6_count", bus.IO_read_data, 8'h03);
    bus.IO_read_strobe = 1'b0;
    repeat (20) tick();
    chk("t6_npulse", txlog.size() - base, 4);
    if (txlog.size() - base == 4)
      for (int i = 0; i < 4; i++)
        chk("t6_order", txlog[base+i], 8'(8'hA1 + i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
